// File: rtl/kontroler_przerwan.sv
// Interrupt controller: edge-latched requests, masking, fixed priority (index 0 highest),
// in-service tracking until RETI. Define INT_NESTING_EN to let strictly higher priority preempt.
module kontroler_przerwan #(
  parameter int          N_SRC     = 4,
  parameter logic [7:0]  VEC_BASE  = 8'h08,
  parameter int          VEC_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             wr_maska,
  input  logic [N_SRC-1:0] dana_maska,
  input  logic             int_en,
  input  logic             int_dis,
  input  logic             reti,
  input  logic             stos_pc_full,
  output logic             jest_przerwanie,
  output logic [7:0]       int_vec,
  output logic             gie,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [0:0] {
    BEZCZYNNY  = 1'b0,
    ZGLOSZENIE = 1'b1
  } stan_t;

  function automatic logic [7:0] vec_of(input int idx);
    int v;
    v = int'(VEC_BASE) + (idx << VEC_SHIFT);
    return v[7:0];
  endfunction

  function automatic logic [N_SRC-1:0] lowest_bit(input logic [N_SRC-1:0] v);
    logic [N_SRC-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      r[i]  = v[i] & ~found;
      found = found | v[i];
    end
    return r;
  endfunction

  stan_t            state_r;
  stan_t            state_next_s;
  logic [N_SRC-1:0] irq_prev_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] maska_r;
  logic [N_SRC-1:0] in_service_r;
  logic             gie_r;
  logic             jest_r;
  logic [7:0]       int_vec_r;
  logic [IDX_W-1:0] idx_r;

  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] blocked_s;
  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] accept_clr_s;
  logic [N_SRC-1:0] reti_clr_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [7:0]       win_vec_s;
  logic             start_s;
  logic             accept_s;
  logic             blk_acc_s;

  assign edge_s       = irq_in & ~irq_prev_r;
  assign elig_s       = pending_r & maska_r & ~blocked_s;
  assign accept_clr_s = accept_s ? (N_SRC'(1'b1) << idx_r) : '0;
  assign reti_clr_s   = (reti && ce) ? lowest_bit(in_service_r) : '0;

  // Blocking mask derived from the in-service set
  always_comb begin
    blocked_s = '0;
    blk_acc_s = 1'b0;
`ifdef INT_NESTING_EN
    for (int i = 0; i < N_SRC; i++) begin
      blk_acc_s    = blk_acc_s | in_service_r[i];
      blocked_s[i] = blk_acc_s;
    end
`else
    blk_acc_s = |in_service_r;
    blocked_s = {N_SRC{blk_acc_s}};
`endif
  end

  // Priority pick: lowest eligible index wins
  always_comb begin
    win_idx_s = '0;
    win_vec_s = 8'h00;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win_idx_s = elig_s[i] ? IDX_W'(i) : win_idx_s;
      win_vec_s = elig_s[i] ? vec_of(i) : win_vec_s;
    end
  end

  // Request FSM next state and transition strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      BEZCZYNNY: begin
        if (gie_r && (elig_s != '0) && !stos_pc_full) begin
          state_next_s = ZGLOSZENIE;
          start_s      = 1'b1;
        end else begin
          state_next_s = BEZCZYNNY;
        end
      end
      ZGLOSZENIE: begin
        if (ce) begin
          accept_s     = 1'b1;
          state_next_s = BEZCZYNNY;
        end else if (stos_pc_full) begin
          state_next_s = BEZCZYNNY;
        end else begin
          state_next_s = ZGLOSZENIE;
        end
      end
      default: begin
        state_next_s = BEZCZYNNY;
      end
    endcase
  end

  // FSM state, request outputs and latched winner
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= BEZCZYNNY;
      jest_r    <= 1'b0;
      int_vec_r <= 8'h00;
      idx_r     <= '0;
    end else begin
      state_r <= state_next_s;
      jest_r  <= (state_next_s == ZGLOSZENIE);
      if (start_s) begin
        int_vec_r <= win_vec_s;
        idx_r     <= win_idx_s;
      end
    end
  end

  // Request latching, mask and in-service bookkeeping; a new edge beats the accept clear
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_r   <= '0;
      pending_r    <= '0;
      maska_r      <= '0;
      in_service_r <= '0;
    end else begin
      irq_prev_r   <= irq_in;
      pending_r    <= (pending_r & ~accept_clr_s) | edge_s;
      in_service_r <= (in_service_r & ~reti_clr_s) | accept_clr_s;
      if (wr_maska) begin
        maska_r <= dana_maska;
      end
    end
  end

  // Global interrupt enable; accept forces it low, CLI beats SEI
  always_ff @(posedge clk) begin
    if (rst) begin
      gie_r <= 1'b0;
    end else if (accept_s) begin
      gie_r <= 1'b0;
    end else if (ce && int_dis) begin
      gie_r <= 1'b0;
    end else if (ce && int_en) begin
      gie_r <= 1'b1;
    end
  end

  assign jest_przerwanie = jest_r;
  assign int_vec         = int_vec_r;
  assign gie             = gie_r;
  assign pending         = pending_r;
  assign in_service      = in_service_r;

endmodule

// File: tb/tb_kontroler_przerwan.sv
// Scoreboard bench for kontroler_przerwan: expected vectors are queued by the stimulus,
// a negedge monitor pops one on every rising jest_przerwanie.
module tb_kontroler_przerwan;

  logic       clk = 1'b0;
  logic       rst, ce, wr_maska, int_en, int_dis, reti, stos_pc_full;
  logic [3:0] irq_in, dana_maska, pending, in_service;
  logic       jest_przerwanie, gie;
  logic [7:0] int_vec;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       prev_jest = 1'b0;

  kontroler_przerwan #(.N_SRC(4), .VEC_BASE(8'h08), .VEC_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .irq_in(irq_in), .wr_maska(wr_maska),
    .dana_maska(dana_maska), .int_en(int_en), .int_dis(int_dis), .reti(reti),
    .stos_pc_full(stos_pc_full), .jest_przerwanie(jest_przerwanie), .int_vec(int_vec),
    .gie(gie), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (jest_przerwanie && !prev_jest) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_request: int_vec=%h, no request expected", int_vec);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (int_vec !== e) begin
            n_err++;
            $display("FAIL int_vec: got %h expected %h", int_vec, e);
          end
        end
      end
      prev_jest = jest_przerwanie;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    wr_maska = 1'b1; dana_maska = m; step(); wr_maska = 1'b0;
  endtask

  task automatic sei();
    int_en = 1'b1; ce = 1'b1; step(); int_en = 1'b0; ce = 1'b0;
  endtask

  task automatic accept();
    ce = 1'b1; step(); ce = 1'b0;
  endtask

  task automatic reti_pulse();
    reti = 1'b1; ce = 1'b1; step(); reti = 1'b0; ce = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] m);
    irq_in = m; step(); irq_in = 4'h0;
  endtask

  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (jest_przerwanie) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: got no request within 10 cycles, expected jest_przerwanie=1", name);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; wr_maska = 1'b0; int_en = 1'b0; int_dis = 1'b0; reti = 1'b0;
    stos_pc_full = 1'b0; irq_in = 4'h0; dana_maska = 4'h0;
    idle(2);
    rst = 1'b0;
    chk("rst_jest", 32'(jest_przerwanie), 32'h0);
    chk("rst_vec", 32'(int_vec), 32'h00);
    chk("rst_gie", 32'(gie), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);

    // single source 2, latency and accept bookkeeping
    write_mask(4'hF);
    sei();
    chk("sei_gie", 32'(gie), 32'h1);
    exp_q.push_back(8'h0C);
    pulse_irq(4'b0100);
    chk("t1_pending", 32'(pending), 32'h4);
    step();
    chk("t1_latency", 32'(jest_przerwanie), 32'h1);
    accept();
    chk("t1_pending_after", 32'(pending), 32'h0);
    chk("t1_in_service", 32'(in_service), 32'h4);
    chk("t1_gie", 32'(gie), 32'h0);
    chk("t1_jest_drop", 32'(jest_przerwanie), 32'h0);
    reti_pulse();
    chk("t1_reti", 32'(in_service), 32'h0);

    // simultaneous edges on 1 and 3
    sei();
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0E);
    pulse_irq(4'b1010);
    wait_req("t2_req_a");
    accept();
    chk("t2_in_service_a", 32'(in_service), 32'h2);
    chk("t2_pending_a", 32'(pending), 32'h8);
    reti_pulse();
    idle(3);
    sei();
    wait_req("t2_req_b");
    accept();
    chk("t2_in_service_b", 32'(in_service), 32'h8);
    reti_pulse();

    // masked source 0, then unmasked
    write_mask(4'b1110);
    sei();
    pulse_irq(4'b0001);
    idle(4);
    chk("t3_pending_masked", 32'(pending), 32'h1);
    chk("t3_no_req", 32'(jest_przerwanie), 32'h0);
    exp_q.push_back(8'h08);
    write_mask(4'hF);
    wait_req("t3_req");
    accept();
    reti_pulse();

    // stack full holds off the request, and aborts a presented one
    sei();
    stos_pc_full = 1'b1;
    pulse_irq(4'b0010);
    idle(4);
    chk("t4_held", 32'(jest_przerwanie), 32'h0);
    chk("t4_pending", 32'(pending), 32'h2);
    exp_q.push_back(8'h0A);
    stos_pc_full = 1'b0;
    step();
    chk("t4_release", 32'(jest_przerwanie), 32'h1);
    stos_pc_full = 1'b1;
    step();
    chk("t4_abort_jest", 32'(jest_przerwanie), 32'h0);
    chk("t4_abort_pending", 32'(pending), 32'h2);
    exp_q.push_back(8'h0A);
    stos_pc_full = 1'b0;
    wait_req("t4_req_again");
    accept();
    reti_pulse();

    // CLI beats SEI; RETI with nothing in service
    sei();
    chk("t5_gie_set", 32'(gie), 32'h1);
    int_en = 1'b1; int_dis = 1'b1; ce = 1'b1; step();
    int_en = 1'b0; int_dis = 1'b0; ce = 1'b0;
    chk("t5_gie_both", 32'(gie), 32'h0);
    reti_pulse();
    chk("t5_reti_empty", 32'(in_service), 32'h0);
    chk("t5_reti_gie", 32'(gie), 32'h0);

    // source 2 in service, then source 0 arrives
    sei();
    exp_q.push_back(8'h0C);
    pulse_irq(4'b0100);
    wait_req("t6_req2");
    accept();
    sei();
`ifdef INT_NESTING_EN
    exp_q.push_back(8'h08);
    pulse_irq(4'b0001);
    wait_req("t6_nest");
    accept();
    chk("t6_in_service_nest", 32'(in_service), 32'h5);
    sei();
    pulse_irq(4'b1000);
    idle(4);
    chk("t6_src3_pending", 32'(pending), 32'h8);
    chk("t6_src3_blocked", 32'(jest_przerwanie), 32'h0);
    exp_q.push_back(8'h0E);
    reti_pulse();
    chk("t6_reti_lowest", 32'(in_service), 32'h4);
    reti_pulse();
    wait_req("t6_src3_req");
    accept();
    reti_pulse();
`else
    pulse_irq(4'b0001);
    idle(4);
    chk("t6_src0_pending", 32'(pending), 32'h1);
    chk("t6_src0_blocked", 32'(jest_przerwanie), 32'h0);
    exp_q.push_back(8'h08);
    reti_pulse();
    wait_req("t6_src0_req");
    accept();
    chk("t6_in_service", 32'(in_service), 32'h1);
    reti_pulse();
`endif

    // edge coinciding with accept of the same source keeps it pending
    sei();
    exp_q.push_back(8'h0A);
    pulse_irq(4'b0010);
    wait_req("t7_req");
    irq_in = 4'b0010; ce = 1'b1; step(); ce = 1'b0; irq_in = 4'h0;
    chk("t7_pending_kept", 32'(pending), 32'h2);
    chk("t7_in_service", 32'(in_service), 32'h2);
    reti_pulse();
    sei();
    exp_q.push_back(8'h0A);
    wait_req("t7_req_again");

    // reset while presenting, with irq 3 held high across release
    rst = 1'b1; irq_in = 4'b1000;
    idle(2);
    chk("t8_rst_jest", 32'(jest_przerwanie), 32'h0);
    chk("t8_rst_pending", 32'(pending), 32'h0);
    chk("t8_rst_gie", 32'(gie), 32'h0);
    chk("t8_rst_in_service", 32'(in_service), 32'h0);
    chk("t8_rst_vec", 32'(int_vec), 32'h00);
    rst = 1'b0;
    step();
    chk("t8_edge_after_rst", 32'(pending), 32'h8);
    irq_in = 4'h0;
    idle(3);
    chk("t8_no_req", 32'(jest_przerwanie), 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
